mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (I port, read-only) and
//  load/store (D port, read/write). Sits between the fetch/execute stages and the memory.
//  One transaction outstanding at a time, variable memory latency, and fixed D-over-I
//  priority with a bounded-starvation override for fetch.
// PARAMETERS
//  MAX_D_STREAK  4   consecutive D grants allowed while i_req is pending before I is forced (>=1)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  i_req       in   1   fetch request; addr held stable until i_gnt
//  i_addr      in   32  fetch byte address
//  i_gnt       out  1   fetch request accepted by memory (1-cycle pulse)
//  i_rvalid    out  1   fetch data valid (1-cycle pulse)
//  i_rdata     out  32  fetch data
//  d_req       in   1   load/store request; all d_* inputs held stable until d_gnt
//  d_we        in   1   1=store, 0=load
//  d_be        in   4   byte enables (stores)
//  d_addr      in   32  data byte address
//  d_wdata     in   32  store data
//  d_gnt       out  1   data request accepted (1-cycle pulse)
//  d_rvalid    out  1   load data / store ack valid (1-cycle pulse)
//  d_rdata     out  32  load data
//  mem_req     out  1   request to memory
//  mem_we      out  1   write enable to memory
//  mem_be      out  4   byte enables to memory
//  mem_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata   out  32  write data
//  mem_ready   in   1   memory accepts request this cycle when mem_req=1
//  mem_rvalid  in   1   response (read data or write ack), >=1 cycle after accept
//  mem_rdata   in   32  read data
//  busy        out  1   transaction outstanding (state != IDLE)
// BEHAVIOUR
//  States: IDLE, WAIT_I, WAIT_D. Reset -> IDLE, streak=0; all outputs 0 during/after reset.
//  IDLE: sel chosen combinationally:
//   - d_req & !(i_req & streak==MAX_D_STREAK) -> D; else i_req -> I; else none.
//   - mem_req=1 iff a port is selected; mem_addr/we/be/wdata mux from selected port.
//   - I selected: mem_we=0, mem_be=4'hF, mem_wdata=0. No selection: mem_* all 0.
//   - mem_ready & sel=D -> d_gnt=1 same cycle, next WAIT_D.
//   - mem_ready & sel=I -> i_gnt=1 same cycle, next WAIT_I.
//   - !mem_ready -> stay IDLE, no gnt; priority is re-evaluated every cycle.
//  WAIT_x: mem_req=0, no grants. On mem_rvalid: x_rvalid=1, x_rdata=mem_rdata
//   (combinational passthrough), next IDLE. Earliest next grant is the following cycle.
//  Minimum transaction: accept cycle + 1 response cycle; 1-cycle memory gives 1 xfer per 2 clk.
//  Non-owner rvalid stays 0. Non-owner rdata is 0.
//  Streak counter, width $clog2(MAX_D_STREAK+1), updates on each grant:
//   - D grant with i_req=1 -> streak+1 (saturates at MAX_D_STREAK).
//   - D grant with i_req=0 -> 0.
//   - I grant -> 0.
//  Edge cases:
//   - mem_rvalid in IDLE (stray/late) is ignored: no rvalid out, no state change.
//   - Requester drops req before gnt: legal; it gets no grant and the other port may win.
//   - Simultaneous i_req & d_req, streak<MAX -> D wins; I waits.
//   - rst mid-transaction -> IDLE immediately; the in-flight response is never forwarded.
//   - addr[1:0] is discarded; d_be carries sub-word selection.
// TESTING
//  1. i_req only, addr=0x104, mem lat 1, rdata=0x00500093
//     -> i_gnt at cycle 0, i_rvalid+data at cycle 1, mem_addr=0x104.
//  2. i_req & d_req (load 0x2002) together
//     -> d_gnt first, mem_addr=0x2000; i_gnt 1 cycle after d_rvalid.
//  3. MAX_D_STREAK=4, i_req and d_req held high continuously
//     -> grant order D,D,D,D,I,D,D,D,D,I...
//  4. Store d_be=4'b0011, wdata=0xDEADBEEF, mem_ready low for 3 cycles
//     -> mem_req held, no gnt; gnt on 4th cycle, d_rvalid on ack.
//  5. rst asserted in WAIT_D, then mem_rvalid=1 after reset
//     -> busy=0, d_rvalid=0, i_rvalid=0; next request granted normally.
//  6. mem_rvalid pulsed in IDLE with no request
//     -> no rvalid out, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// One transaction in flight; D has priority unless fetch has been starved for MAX_D_STREAK grants.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          sel_d, sel_i;

  // Fetch is forced only when it is actually waiting and D has used up its streak.
  assign sel_d = (state_q == IDLE) && d_req && !(i_req && (streak_q == STREAK_MAX));
  assign sel_i = (state_q == IDLE) && !sel_d && i_req;

  // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    i_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Outputs are held quiet while reset is asserted, even with requests pending.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (sel_d) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = {d_addr[31:2], 2'b00};
            mem_wdata = d_wdata;
            if (mem_ready) begin
              d_gnt    = 1'b1;
              state_d  = WAIT_D;
              if (!i_req)                   streak_d = '0;
              else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
            end
          end else if (sel_i) begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = {i_addr[31:2], 2'b00};
            if (mem_ready) begin
              i_gnt    = 1'b1;
              state_d  = WAIT_I;
              streak_d = '0;
            end
          end
        end
        WAIT_I: begin
          if (mem_rvalid) begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
            state_d  = IDLE;
          end
        end
        WAIT_D: begin
          if (mem_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign busy = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of combinational IDLE-select vectors
// followed by hand-written multi-cycle sequences with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // mem_ready=0 throughout the table, so the DUT stays in IDLE and only the select mux is observed.
    vecs[0] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,    0, 0, 4'h0, 32'h0,    32'h0};
    vecs[1] = '{1, 32'h107, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,    1, 0, 4'hF, 32'h104,  32'h0};
    vecs[2] = '{0, 32'h0,   1, 1, 4'h5, 32'h2003, 32'h12345678, 0, 32'h0,    1, 1, 4'h5, 32'h2000, 32'h12345678};
    vecs[3] = '{1, 32'h200, 1, 0, 4'hF, 32'h40,   32'hAAAA,     0, 32'h0,    1, 0, 4'hF, 32'h40,   32'hAAAA};
    vecs[4] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,        1, 32'hCAFE, 0, 0, 4'h0, 32'h0,    32'h0};
    vecs[5] = '{1, 32'h3FE, 0, 1, 4'h3, 32'h10,   32'h99,       0, 32'h0,    1, 0, 4'hF, 32'h3FC,  32'h0};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    check("reset busy", busy, 0);
    check("reset mem_req", mem_req, 0);
    check("reset gnts", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
      d_req = vecs[k].d_req; d_we = vecs[k].d_we; d_be = vecs[k].d_be;
      d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
      mem_ready = 0; mem_rvalid = vecs[k].mem_rvalid; mem_rdata = vecs[k].mem_rdata;
      #1;
      check($sformatf("vec%0d mem_req", k), mem_req, vecs[k].e_req);
      check($sformatf("vec%0d mem_we", k), mem_we, vecs[k].e_we);
      check($sformatf("vec%0d mem_be", k), mem_be, vecs[k].e_be);
      check($sformatf("vec%0d mem_addr", k), mem_addr, vecs[k].e_addr);
      check($sformatf("vec%0d mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      check($sformatf("vec%0d no gnt/rvalid", k), {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
      check($sformatf("vec%0d rdata zero", k), i_rdata | d_rdata, 0);
      check($sformatf("vec%0d busy", k), busy, 0);
    end

    // Single fetch with 1-cycle memory.
    @(negedge clk); idle_inputs();
    i_req = 1; i_addr = 32'h104; mem_ready = 1; #1;
    check("s1 i_gnt", i_gnt, 1);
    check("s1 mem_addr", mem_addr, 32'h104);
    @(negedge clk); i_req = 0; mem_rvalid = 1; mem_rdata = 32'h00500093; #1;
    check("s1 i_rvalid", i_rvalid, 1);
    check("s1 i_rdata", i_rdata, 32'h00500093);
    check("s1 d_rvalid off", {d_rvalid, d_rdata}, 0);
    check("s1 busy", busy, 1);
    check("s1 no mem_req in wait", mem_req, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    check("s1 back idle", busy, 0);

    // Simultaneous requests: D first, I one cycle after d_rvalid.
    @(negedge clk); idle_inputs();
    i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h2002; d_be = 4'hF; mem_ready = 1; #1;
    check("s2 d_gnt", {i_gnt, d_gnt}, 2'b01);
    check("s2 mem_addr", mem_addr, 32'h2000);
    @(negedge clk); d_req = 0; mem_rvalid = 1; mem_rdata = 32'h11223344; #1;
    check("s2 d_rvalid", d_rvalid, 1);
    check("s2 d_rdata", d_rdata, 32'h11223344);
    check("s2 no i_gnt in wait", i_gnt, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    check("s2 i_gnt", {i_gnt, d_gnt}, 2'b10);
    check("s2 i mem_addr", mem_addr, 32'h200);
    @(negedge clk); i_req = 0; mem_rvalid = 1; #1;
    check("s2 i_rvalid", i_rvalid, 1);

    // Both held: grant order D,D,D,D,I repeating (streak was cleared by the I grant above).
    @(negedge clk); idle_inputs();
    i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h400; d_be = 4'hF; mem_ready = 1;
    for (int g = 0; g < 10; g++) begin
      #1;
      check($sformatf("s3 grant%0d", g), {i_gnt, d_gnt}, (g % 5 == 4) ? 2'b10 : 2'b01);
      @(negedge clk); mem_rvalid = 1; #1;
      check($sformatf("s3 rvalid%0d", g), {i_rvalid, d_rvalid}, (g % 5 == 4) ? 2'b10 : 2'b01);
      @(negedge clk); mem_rvalid = 0;
    end

    // Store with memory stalling three cycles.
    idle_inputs();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h3001; d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("s4 stall%0d req", c), {mem_req, mem_we, mem_be}, {1'b1, 1'b1, 4'b0011});
      check($sformatf("s4 stall%0d wdata", c), mem_wdata, 32'hDEADBEEF);
      check($sformatf("s4 stall%0d no gnt", c), d_gnt, 0);
      @(negedge clk);
    end
    mem_ready = 1; #1;
    check("s4 d_gnt", d_gnt, 1);
    check("s4 addr", mem_addr, 32'h3000);
    @(negedge clk); d_req = 0; mem_ready = 0; mem_rvalid = 1; #1;
    check("s4 ack", d_rvalid, 1);
    @(negedge clk); mem_rvalid = 0;

    // Reset while waiting on a load; the late response must not be forwarded.
    d_req = 1; d_we = 0; d_addr = 32'h500; d_be = 4'hF; mem_ready = 1; #1;
    check("s5 d_gnt", d_gnt, 1);
    @(negedge clk); rst = 1; #1;
    check("s5 busy in reset", busy, 0);
    check("s5 outputs quiet in reset", {mem_req, i_gnt, d_gnt}, 0);
    @(negedge clk); rst = 0; d_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h55; #1;
    check("s5 late rvalid dropped", {i_rvalid, d_rvalid}, 0);
    check("s5 late rdata dropped", d_rdata, 0);
    check("s5 busy after reset", busy, 0);
    @(negedge clk); mem_rvalid = 0; i_req = 1; i_addr = 32'h600; mem_ready = 1; #1;
    check("s5 next grant", i_gnt, 1);
    @(negedge clk); i_req = 0; mem_rvalid = 1; mem_rdata = 32'h77; #1;
    check("s5 next rdata", i_rdata, 32'h77);

    // Stray response in IDLE: ignored, no state change.
    @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'hBAD; #1;
    check("s6 stray rvalid", {i_rvalid, d_rvalid}, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    check("s6 still idle", busy, 0);
    i_req = 1; i_addr = 32'h8; mem_ready = 1; #1;
    check("s6 grant after stray", i_gnt, 1);
    @(negedge clk); idle_inputs(); mem_rvalid = 1;
    @(negedge clk); mem_rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
